// File: rtl/cc_serializer.sv
// R-channel read-data responder: captures a full cache line and streams it
// as a wrap burst of DATA_WIDTH beats, starting at the requested word.
module cc_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_CNT   = LINE_WIDTH / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_valid_i,
  output logic                  line_ready_o,
  input  logic [LINE_WIDTH-1:0] line_data_i,
  input  logic [5:0]            line_offset_i,
  output logic                  inct_rvalid_o,
  input  logic                  inct_rready_i,
  output logic [DATA_WIDTH-1:0] inct_rdata_o,
  output logic [1:0]            inct_rresp_o,
  output logic                  inct_rlast_o,
  output logic                  busy_o
);

  localparam int IDX_W  = (BEAT_CNT > 1) ? $clog2(BEAT_CNT) : 1;
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEAT_CNT - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  handshake;
  logic                  last_hs;
  logic                  accept;
  logic [IDX_W-1:0]      start_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  unused_offset;

  // Byte-within-word bits of the request offset do not affect beat order.
  assign unused_offset = ^line_offset_i[BYTE_W-1:0];
  assign start_idx     = line_offset_i[BYTE_W +: IDX_W];

  assign handshake    = rvalid_q & inct_rready_i;
  assign last_hs      = handshake & rlast_q;
  // Ready in the final-beat cycle lets the next line follow with no bubble.
  assign line_ready_o = (state_q == IDLE) | last_hs;
  assign accept       = line_valid_i & line_ready_o;
  assign next_idx     = idx_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;

    if (accept) begin
      state_d  = SEND;
      buf_d    = line_data_i;
      idx_d    = start_idx;
      cnt_d    = '0;
      rvalid_d = 1'b1;
      rlast_d  = (LAST_BEAT == '0);
      rdata_d  = line_data_i[start_idx*DATA_WIDTH +: DATA_WIDTH];
    end else if (last_hs) begin
      state_d  = IDLE;
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end else if (handshake) begin
      // Index wraps naturally because BEAT_CNT is a power of two.
      idx_d    = next_idx;
      cnt_d    = cnt_q + 1'b1;
      rlast_d  = ((cnt_q + 1'b1) == LAST_BEAT);
      rdata_d  = buf_q[next_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the line buffer is reset too so no X leaks onto rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

  assign inct_rvalid_o = rvalid_q;
  assign inct_rdata_o  = rdata_q;
  assign inct_rlast_o  = rlast_q;
  assign inct_rresp_o  = 2'b00;
  assign busy_o        = (state_q == SEND);

endmodule

// File: tb/tb_cc_serializer.sv
// Self-checking bench for cc_serializer: a queue-of-beats reference model is
// compared every cycle, plus directed bursts with literal beat orders.
module tb_cc_serializer;

  localparam int DW = 64;
  localparam int LW = 512;
  localparam int BC = 8;

  logic          clk;
  logic          rst_n;
  logic          line_valid_i;
  logic          line_ready_o;
  logic [LW-1:0] line_data_i;
  logic [5:0]    line_offset_i;
  logic          inct_rvalid_o;
  logic          inct_rready_i;
  logic [DW-1:0] inct_rdata_o;
  logic [1:0]    inct_rresp_o;
  logic          inct_rlast_o;
  logic          busy_o;

  cc_serializer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_valid_i  (line_valid_i),
    .line_ready_o  (line_ready_o),
    .line_data_i   (line_data_i),
    .line_offset_i (line_offset_i),
    .inct_rvalid_o (inct_rvalid_o),
    .inct_rready_i (inct_rready_i),
    .inct_rdata_o  (inct_rdata_o),
    .inct_rresp_o  (inct_rresp_o),
    .inct_rlast_o  (inct_rlast_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the beats still owed to the interconnect, in order.
  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    model_s;
  bit    exp_valid;
  bit    exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_rvalid", inct_rvalid_o, 0);
      check("rst_rlast",  inct_rlast_o,  0);
      check("rst_busy",   busy_o,        0);
      check("rst_ready",  line_ready_o,  1);
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && inct_rready_i);
      check("rvalid", inct_rvalid_o, exp_valid);
      check("busy",   busy_o,        exp_valid);
      check("ready",  line_ready_o,  exp_ready);
      check("rresp",  inct_rresp_o,  0);
      if (exp_valid) begin
        check("rdata", inct_rdata_o, exp_q[0].data);
        check("rlast", inct_rlast_o, exp_q[0].last);
      end
      if (exp_valid && inct_rready_i) void'(exp_q.pop_front());
      if (line_valid_i && exp_ready) begin
        model_s = int'(line_offset_i) / 8;
        for (int k = 0; k < BC; k++)
          exp_q.push_back('{data: line_data_i[((model_s + k) % BC)*DW +: DW], last: (k == BC-1)});
      end
    end
  end

  // Handshake capture, for directed order and contiguity checks.
  logic [63:0] got[$];
  int          got_cyc[$];
  int          cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && inct_rvalid_o && inct_rready_i) begin
      got.push_back(inct_rdata_o);
      got_cyc.push_back(cyc);
    end
  end

  int rr_mode = 0;
  int rr_tog  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (rr_mode)
      0: inct_rready_i = 1'b1;
      1: begin
        inct_rready_i = (rr_tog % 3 == 0);
        rr_tog++;
      end
      default: inct_rready_i = ($urandom_range(0, 3) != 0);
    endcase
    #1;
  endtask

  function automatic logic [LW-1:0] line_of(input logic [63:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < BC; k++) l[k*DW +: DW] = base + 64'(k);
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic offer(input logic [LW-1:0] d, input logic [5:0] off);
    int g = 0;
    line_valid_i  = 1'b1;
    line_data_i   = d;
    line_offset_i = off;
    #1;
    while (!line_ready_o && g < 100) begin
      step();
      g++;
    end
    check("offer_accepted", line_ready_o, 1);
    step();
    line_valid_i  = 1'b0;
    line_data_i   = rand_line();
    line_offset_i = 6'($urandom);
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    while (got.size() < n && g < 200) begin
      step();
      g++;
    end
    check("beats_arrived", got.size() >= n, 1);
  endtask

  task automatic check_seq(input string name, input logic [63:0] base, input int ord[8], input int first);
    for (int i = 0; i < BC; i++)
      check(name, (first + i < got.size()) ? got[first + i] : 64'hdead, base + 64'(ord[i]));
  endtask

  task automatic contig(input string name, input int n);
    for (int i = 1; i < n; i++)
      check(name, (i < got_cyc.size()) ? 64'(got_cyc[i] - got_cyc[0]) : 64'hdead, 64'(i));
  endtask

  task automatic clear_got();
    got.delete();
    got_cyc.delete();
  endtask

  int ord_0[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
  int ord_28[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
  int ord_3f[8] = '{7, 0, 1, 2, 3, 4, 5, 6};
  int ord_18[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
  int ord_10[8] = '{2, 3, 4, 5, 6, 7, 0, 1};
  int ord_20[8] = '{4, 5, 6, 7, 0, 1, 2, 3};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 remaining", 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    line_valid_i  = 1'b0;
    line_data_i   = '0;
    line_offset_i = '0;
    inct_rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata",  inct_rdata_o,  0);
    check("reset_rvalid", inct_rvalid_o, 0);
    check("reset_rlast",  inct_rlast_o,  0);
    check("reset_busy",   busy_o,        0);
    check("reset_ready",  line_ready_o,  1);
    rst_n = 1'b1;
    step();

    // Aligned burst, rready held high.
    rr_mode = 0;
    clear_got();
    offer(line_of(64'h0), 6'h00);
    wait_beats(8);
    check_seq("t1_order", 64'h0, ord_0, 0);
    contig("t1_contig", 8);
    check("t1_ready_after", line_ready_o, 1);
    check("t1_idle_after", busy_o, 0);

    // Mid-line critical word.
    clear_got();
    offer(line_of(64'h100), 6'h28);
    wait_beats(8);
    check_seq("t2_order", 64'h100, ord_28, 0);

    // Top word; byte bits ignored.
    clear_got();
    offer(line_of(64'h200), 6'h3F);
    wait_beats(8);
    check_seq("t3_order", 64'h200, ord_3f, 0);

    // Stalls with rready 1,0,0 repeating.
    rr_mode = 1;
    rr_tog  = 0;
    clear_got();
    offer(line_of(64'h300), 6'h18);
    wait_beats(8);
    repeat (4) step();
    check("t4_beat_count", got.size(), 8);
    check_seq("t4_order", 64'h300, ord_18, 0);

    // Back-to-back lines with no bubble.
    rr_mode = 0;
    repeat (2) step();
    clear_got();
    offer(line_of(64'h400), 6'h00);
    offer(line_of(64'h500), 6'h10);
    wait_beats(16);
    check_seq("t5_line_a", 64'h400, ord_0, 0);
    check_seq("t5_line_b", 64'h500, ord_10, 8);
    contig("t5_contig", 16);

    // Reset after the third beat aborts the burst.
    repeat (2) step();
    clear_got();
    offer(line_of(64'h600), 6'h00);
    wait_beats(3);
    rst_n = 1'b0;
    #1;
    check("t6_rvalid_abort", inct_rvalid_o, 0);
    check("t6_busy_abort",   busy_o,        0);
    repeat (2) step();
    check("t6_beats_stopped", got.size(), 3);
    rst_n = 1'b1;
    step();
    clear_got();
    offer(line_of(64'h700), 6'h20);
    wait_beats(8);
    check_seq("t6_restart", 64'h700, ord_20, 0);

    // Randomized traffic checked by the model every cycle.
    rr_mode = 2;
    repeat (3000) begin
      step();
      line_valid_i  = $urandom_range(0, 1);
      line_data_i   = rand_line();
      line_offset_i = 6'($urandom);
    end
    line_valid_i = 1'b0;
    begin
      int g = 0;
      while (busy_o && g < 100) begin
        step();
        g++;
      end
    end
    check("drain_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
